speck_round_ctrl: RTL and testbench
===================================

SPECK_ROUND_CTRL -- requirements
Module: speck_round_ctrl

Interface
REQ-001 Parameter: ROUNDS, 32, number of SPECK128/128 rounds applied per block.
REQ-002 Parameter: KS_TIMEOUT, 64, maximum cycles to wait for ks_finished (used only when SPECK_CTRL_TIMEOUT_EN is defined).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 start  in  1  request encryption; sampled only in IDLE.
REQ-006 key  in  128  [127:64]=l0, [63:0]=k0; sampled on the accepted start.
REQ-007 plaintext  in  128  [127:64]=x, [63:0]=y; sampled on the accepted start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse when ciphertext becomes valid.
REQ-010 error  out  1  one-cycle pulse on key-schedule timeout.
REQ-011 ciphertext  out  128  [127:64]=x, [63:0]=y; held until the next accepted start.
REQ-012 ks_start  out  1  one-cycle request to the external key-schedule unit.
REQ-013 ks_key_in  out  128  current {l, k} presented to the key-schedule unit; stable from ks_start until ks_finished.
REQ-014 ks_round  out  6  index of the round whose key is being expanded; stable with ks_key_in.
REQ-015 ks_finished  in  1  key-schedule completion strobe.
REQ-016 ks_key_out  in  128  next {l, k}; valid in the cycle ks_finished is high.

Function
REQ-017 States SHALL be IDLE, LOAD, ROUND, KS_REQ, KS_WAIT, DONE.
REQ-018 IDLE->LOAD on start; LOAD SHALL latch x, y, k, l from the inputs and clear the round counter.
REQ-019 LOAD->ROUND unconditionally.
REQ-020 ROUND SHALL apply one round in one cycle: x' = (ROR64(x,8) + y) ^ k (mod 2^64); y' = ROL64(y,3) ^ x'.
REQ-021 ROUND->DONE when round counter = ROUNDS-1; otherwise ROUND->KS_REQ.
REQ-022 KS_REQ SHALL assert ks_start for exactly one cycle, with ks_round = round counter, then go to KS_WAIT.
REQ-023 KS_WAIT SHALL hold until ks_finished; on ks_finished it SHALL latch {l, k} from ks_key_out, increment the round counter, and go to ROUND.
REQ-024 ks_finished SHALL be ignored outside KS_WAIT; ks_finished in the same cycle as ks_start SHALL NOT be accepted.
REQ-025 DONE SHALL copy {x, y} to ciphertext, pulse done, and return to IDLE.
REQ-026 start while busy SHALL be ignored; start in the cycle done is high SHALL be ignored; start in the IDLE cycle after DONE SHALL be accepted.
REQ-027 Latency from the accepted start to done, with ks_finished latency L cycles after ks_start, SHALL be 2 + ROUNDS + (ROUNDS-1)*(1+L) cycles.

Reset
REQ-028 With rst_n low at posedge clk: state=IDLE, busy=0, done=0, error=0, ks_start=0, ciphertext=0, round counter=0, ks_round=0, ks_key_in=0.
REQ-029 Reset mid-operation SHALL abort the operation with no done pulse; a ks_finished arriving after reset SHALL be ignored.

Configuration
REQ-030 Macro SPECK_CTRL_TIMEOUT_EN: when defined, a cycle counter SHALL run in KS_WAIT; if ks_finished has not arrived after KS_TIMEOUT cycles, the block SHALL pulse error, leave ciphertext unchanged, and return to IDLE.
REQ-031 When SPECK_CTRL_TIMEOUT_EN is undefined, KS_WAIT SHALL wait indefinitely, and error SHALL be tied to 0.

Verification
REQ-032 Test vector: key=0f0e0d0c0b0a0908_0706050403020100, plaintext=6c61766975716520_7469206564616d20, with a behavioural key-schedule model -> ciphertext=a65d985179783265_7860fedf5c570d18, and exactly one done pulse.
REQ-033 Latency: model with L=3 -> done asserts exactly 2+32+31*4=158 cycles after the accepted start; ks_round sequence 0..30, each ks_start one cycle wide.
REQ-034 Start while busy: start pulsed at cycles 5 and 40 after the first start -> result identical to REQ-032; no second operation is begun.
REQ-035 Reset mid-run: rst_n low for one cycle during KS_WAIT of round 10 -> all outputs at their reset values; a late ks_finished causes no state change; a fresh start then yields the REQ-032 result.
REQ-036 Timeout (macro defined, KS_TIMEOUT=64): model never asserts ks_finished -> error pulses once 64 cycles after entering KS_WAIT, busy drops, ciphertext unchanged, done never asserts.
REQ-037 Back-to-back: start asserted in the IDLE cycle immediately after done -> accepted; second result is correct.

Source files
------------

// File: rtl/speck_round_ctrl.sv
// speck_round_ctrl: SPECK128/128 round sequencer driving an external key-schedule unit.
// Define SPECK_CTRL_TIMEOUT_EN to abort with an error pulse when ks_finished never arrives.
module speck_round_ctrl #(
    parameter int ROUNDS     = 32,
    parameter int KS_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [127:0] ciphertext,
    output logic         ks_start,
    output logic [127:0] ks_key_in,
    output logic [5:0]   ks_round,
    input  logic         ks_finished,
    input  logic [127:0] ks_key_out
);
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, KS_REQ, KS_WAIT, DONE} state_t;
    state_t state;
    logic [63:0] x, y, x_next, y_next;
    // ks_key_in doubles as the working {l, k} register; k is its low half
    assign x_next = ({x[7:0], x[63:8]} + y) ^ ks_key_in[63:0];
    assign y_next = {y[60:0], y[63:61]} ^ x_next;
`ifdef SPECK_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(KS_TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
`else
    assign error = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            ks_start   <= 1'b0;
            ciphertext <= '0;
            ks_round   <= '0;
            ks_key_in  <= '0;
            x          <= '0;
            y          <= '0;
`ifdef SPECK_CTRL_TIMEOUT_EN
            error      <= 1'b0;
            wait_cnt   <= '0;
`endif
        end else begin
            done     <= 1'b0;
            ks_start <= 1'b0;
`ifdef SPECK_CTRL_TIMEOUT_EN
            error    <= 1'b0;
`endif
            case (state)
                IDLE: if (start) begin
                    state     <= LOAD;
                    busy      <= 1'b1;
                    {x, y}    <= plaintext;
                    ks_key_in <= key;
                end
                LOAD: begin
                    state    <= ROUND;
                    ks_round <= '0;
                end
                ROUND: begin
                    x <= x_next;
                    y <= y_next;
                    if (ks_round == 6'(ROUNDS - 1)) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        ciphertext <= {x_next, y_next};
                    end else begin
                        state    <= KS_REQ;
                        ks_start <= 1'b1;
                    end
                end
                KS_REQ: begin
                    state <= KS_WAIT;
`ifdef SPECK_CTRL_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                KS_WAIT: begin
                    if (ks_finished) begin
                        ks_key_in <= ks_key_out;
                        ks_round  <= ks_round + 6'd1;
                        state     <= ROUND;
                    end
`ifdef SPECK_CTRL_TIMEOUT_EN
                    else if (wait_cnt == CW'(KS_TIMEOUT - 1)) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_speck_round_ctrl.sv
// tb_speck_round_ctrl: randomized scoreboard bench with a behavioural key-schedule unit.
module tb_speck_round_ctrl;
    localparam int ROUNDS     = 32;
    localparam int KS_TIMEOUT = 64;
    localparam logic [127:0] TV_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] TV_PT  = 128'h6c61766975716520_7469206564616d20;
    localparam logic [127:0] TV_CT  = 128'ha65d985179783265_7860fedf5c570d18;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] plaintext = '0;
    logic         busy, done, error, ks_start;
    logic [127:0] ciphertext, ks_key_in;
    logic [5:0]   ks_round;
    logic         ks_finished = 1'b0;
    logic [127:0] ks_key_out = '0;

    speck_round_ctrl #(.ROUNDS(ROUNDS), .KS_TIMEOUT(KS_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .plaintext(plaintext),
        .busy(busy), .done(done), .error(error), .ciphertext(ciphertext),
        .ks_start(ks_start), .ks_key_in(ks_key_in), .ks_round(ks_round),
        .ks_finished(ks_finished), .ks_key_out(ks_key_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] ct;
        int           t0;
        int           lat;
    } exp_t;
    exp_t exp_q[$];
    logic [127:0] exp_keys [ROUNDS];
    int op_id = 0;
    int ks_lat = 3;
    bit ks_stall = 1'b0;
    int ks_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int tests = 0;
    int fails = 0;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [63:0] rol(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [127:0] ks_step(input logic [127:0] lk, input int i);
        logic [63:0] l2, k2;
        l2 = (lk[63:0] + ror(lk[127:64], 8)) ^ 64'(i);
        k2 = rol(lk[63:0], 3) ^ l2;
        return {l2, k2};
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [63:0] xv, yv;
        logic [127:0] lk;
        xv = p[127:64];
        yv = p[63:0];
        lk = k;
        for (int i = 0; i < ROUNDS; i++) begin
            xv = (ror(xv, 8) + yv) ^ lk[63:0];
            yv = rol(yv, 3) ^ xv;
            lk = ks_step(lk, i);
        end
        return {xv, yv};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int lat_of(input int l);
        return 2 + ROUNDS + (ROUNDS - 1) * (1 + l);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 128'(busy), 0);
        check({tag, "_done"}, 128'(done), 0);
        check({tag, "_error"}, 128'(error), 0);
        check({tag, "_ks_start"}, 128'(ks_start), 0);
        check({tag, "_ciphertext"}, ciphertext, 0);
        check({tag, "_ks_round"}, 128'(ks_round), 0);
        check({tag, "_ks_key_in"}, ks_key_in, 0);
    endtask

    task automatic push_exp(input logic [127:0] k, input logic [127:0] p, input int l,
                            input bit timed, input int t0);
        exp_t e;
        op_id++;
        exp_keys[0] = k;
        for (int i = 1; i < ROUNDS; i++) exp_keys[i] = ks_step(exp_keys[i-1], i - 1);
        e.ct  = (k == TV_KEY && p == TV_PT) ? TV_CT : encrypt(k, p);
        e.t0  = t0;
        e.lat = timed ? lat_of(l) : -1;
        exp_q.push_back(e);
    endtask

    task automatic start_op(input logic [127:0] k, input logic [127:0] p, input int l, input bit timed);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            cycle();
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL idle_wait: busy still %0d after %0d cycles, required 0", busy, n);
        end
        ks_lat    = l;
        start     = 1'b1;
        key       = k;
        plaintext = p;
        push_exp(k, p, l, timed, cyc);
        cycle();
        start = 1'b0;
        cycle();
        key       = rnd128();
        plaintext = rnd128();
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_done_timeout: done %0d after %0d cycles, required 1", name, done, n);
        end
        check({name, "_ks_requests"}, 128'(ks_cnt), ROUNDS - 1);
        check({name, "_error"}, 128'(error), 0);
    endtask

    task automatic wait_ks_start(input int rnd);
        int n;
        n = 0;
        while (!(ks_start && ks_round == 6'(rnd)) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!ks_start) begin
            tests++;
            fails++;
            $display("FAIL ks_start_wait: no request for round %0d after %0d cycles", rnd, n);
        end
    endtask

    // Behavioural key-schedule unit; acts 2 time units after each edge so it sees the bench's drives
    initial begin : ks_model
        int rem;
        bit held, prev_start;
        int seen_op;
        logic [127:0] req_key;
        logic [5:0] req_round;
        rem = 0;
        held = 1'b0;
        prev_start = 1'b0;
        seen_op = 0;
        req_key = '0;
        req_round = '0;
        forever begin
            @(posedge clk);
            #2;
            ks_finished = 1'b0;
            if (seen_op != op_id) begin
                seen_op = op_id;
                rem = 0;
                held = 1'b0;
                ks_cnt = 0;
            end
            if (held && !ks_stall) begin
                held = 1'b0;
                rem = 1;
            end
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    ks_finished = 1'b1;
                    ks_key_out = ks_step(req_key, int'(req_round));
                end
            end
            if (ks_start) begin
                check("ks_start_width", 128'(prev_start), 0);
                if (ks_cnt >= ROUNDS - 1) begin
                    tests++;
                    fails++;
                    $display("FAIL ks_extra_request: request %0d, at most %0d allowed", ks_cnt + 1, ROUNDS - 1);
                end else begin
                    check("ks_round", 128'(ks_round), 128'(ks_cnt));
                    check("ks_key_in", ks_key_in, exp_keys[ks_cnt]);
                end
                ks_cnt++;
                req_key = ks_key_in;
                req_round = ks_round;
                if (ks_stall) held = 1'b1;
                else rem = ks_lat;
            end
            prev_start = ks_start;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (error) err_cnt++;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: ciphertext %0h with no outstanding request", ciphertext);
                end else begin
                    e = exp_q.pop_front();
                    check("ciphertext", ciphertext, e.ct);
                    if (e.lat >= 0) check("latency", 128'(cyc - e.t0), 128'(e.lat));
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0, e0, t;
        logic [127:0] k2, p2, ct_before;
        repeat (3) cycle();
        check_reset("reset");
        rst_n = 1'b1;
        cycle();

        start_op(TV_KEY, TV_PT, 3, 1'b1);
        wait_done("tv");

        for (int i = 0; i < 4; i++) begin
            start_op(rnd128(), rnd128(), int'($urandom_range(1, 5)), 1'b1);
            wait_done("rand");
        end

        // stray starts while busy must not restart or alter the running block
        start_op(TV_KEY, TV_PT, 3, 1'b1);
        repeat (3) cycle();
        start = 1'b1;
        key = rnd128();
        cycle();
        start = 1'b0;
        repeat (34) cycle();
        start = 1'b1;
        plaintext = rnd128();
        cycle();
        start = 1'b0;
        wait_done("busy_start");
        repeat (5) cycle();
        check("busy_start_idle", 128'(busy), 0);

        // start held through the done cycle is taken in the following idle cycle only
        start_op(rnd128(), rnd128(), 2, 1'b1);
        wait_done("b2b_first");
        k2 = rnd128();
        p2 = rnd128();
        start = 1'b1;
        key = k2;
        plaintext = p2;
        ks_lat = 4;
        push_exp(k2, p2, 4, 1'b1, cyc + 1);
        cycle();
        cycle();
        start = 1'b0;
        cycle();
        key = rnd128();
        wait_done("b2b_second");

        // reset during the round-10 key-schedule wait, then a late ks_finished
        start_op(TV_KEY, TV_PT, 3, 1'b1);
        wait_ks_start(10);
        d0 = done_cnt;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        exp_q.delete();
        check_reset("mid_reset");
        cycle();
        cycle();
        check_reset("late_finish");
        check("late_finish_no_done", 128'(done_cnt), 128'(d0));
        start_op(TV_KEY, TV_PT, 3, 1'b1);
        wait_done("after_reset");

`ifdef SPECK_CTRL_TIMEOUT_EN
        ct_before = ciphertext;
        e0 = err_cnt;
        d0 = done_cnt;
        ks_stall = 1'b1;
        start_op(rnd128(), rnd128(), 3, 1'b0);
        wait_ks_start(0);
        t = cyc;
        while (!error && cyc - t < 300) @(negedge clk);
        check("timeout_latency", 128'(cyc - t), 128'(KS_TIMEOUT + 1));
        check("timeout_busy", 128'(busy), 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("timeout_error_once", 128'(err_cnt - e0), 1);
        check("timeout_no_done", 128'(done_cnt), 128'(d0));
        check("timeout_ciphertext", ciphertext, ct_before);
        ks_stall = 1'b0;
        start_op(TV_KEY, TV_PT, 3, 1'b1);
        wait_done("after_timeout");
`else
        ks_stall = 1'b1;
        start_op(rnd128(), rnd128(), 2, 1'b0);
        wait_ks_start(0);
        repeat (200) @(negedge clk);
        check("stall_busy", 128'(busy), 1);
        check("stall_no_error", 128'(err_cnt), 0);
        ks_stall = 1'b0;
        wait_done("stall");
        check("no_error_ever", 128'(err_cnt), 0);
`endif
        repeat (3) cycle();
        check("scoreboard_drained", 128'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
